iommu_msi_sched: RTL and testbench
==================================

// Module: iommu_msi_sched
// PURPOSE
//  Schedules MSI generation for all IOMMU interrupt sources (CQ, FQ, HPM, PQ) onto one MSI writer.
//  Detects rising edges of per-source pending bits, holds messages whose vector is masked and
//  round-robin-arbitrates eligible sources. Issues one {src,vec} request at a time over valid/ready.
//  Sits between the register file (ip/iv/mask) and the AXI MSI write engine.
// PARAMETERS
//  N_SRC  4   number of interrupt sources; index = iommu_ig_pkg::src_e
//  N_VEC  16  MSI config table entries
//  VEC_W  $clog2(N_VEC)  vector index width (derived, not overridden)
// PORTS
//  clk_i         in   1            clock
//  rst_i         in   1            reset, synchronous, active-high
//  msi_en_i      in   1            MSI generation enabled (fctl/caps)
//  ip_i          in   N_SRC        interrupt-pending bits, level
//  iv_i          in   N_SRC*VEC_W  vector per source
//  vec_masked_i  in   N_VEC        MSI vector-control mask bits
//  req_valid_o   out  1            MSI request to writer
//  req_src_o     out  SRC_W        granted source
//  req_vec_o     out  VEC_W        vector captured at grant
//  req_ready_i   in   1            writer accepts request
//  done_i        in   1            writer finished (B response consumed)
//  err_i         in   1            qualifies done_i: write returned error
//  pend_o        out  N_SRC        message pending per source
//  busy_o        out  1            FSM not in IDLE
//  msi_error_o   out  1            one-cycle pulse on write error
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=IDLE, pend_q=0, ip_q=0, rr_q=0, all outputs 0. Aborts any
//   in-flight request; writer is reset by the same rst_i.
//  Edge detect: ip_q<=ip_i every cycle regardless of msi_en_i. Event[s] = ip_i[s]&~ip_q[s]&msi_en_i.
//   Event sets pend_q[s] next cycle; multiple events while pending coalesce into one message.
//   Level high straight out of reset counts as an edge (ip_q resets to 0).
//  Eligible[s] = pend_q[s] & ~vec_masked_i[iv_i[s]] & msi_en_i. Masked pendings wait indefinitely.
//  Arbitration: round-robin, search starts at rr_q upward modulo N_SRC; on grant rr_q<=g+1 mod N_SRC.
//  FSM:
//   IDLE: if any eligible -> grant g, latch src=g, vec=iv_i[g], clear pend_q[g], go REQ.
//   REQ:  req_valid_o=1, src/vec stable; on req_ready_i -> WAIT. Must not drop valid before ready.
//   WAIT: on done_i -> IDLE; if err_i also 1, msi_error_o=1 that cycle. done_i ignored outside WAIT.
//  Set-over-clear: an event on g in the grant cycle leaves pend_q[g]=1 (second MSI follows).
//  Mask set after grant does not cancel the committed request. Errored message is not retried.
//  msi_en_i falling: no new grants; current REQ/WAIT completes; pend_q retained, resumes on re-enable.
//  Latency: edge at cycle t -> pend at t+1 -> req_valid_o at t+2 (idle, unmasked).
//  pend_o=pend_q; busy_o=(state!=IDLE). Back-to-back: IDLE one cycle minimum between requests.
// STRUCTURE
//  iommu_ig_pkg: src_e {SRC_CQ=0,SRC_FQ=1,SRC_HPM=2,SRC_PQ=3}, SRC_W, N_VEC, msi_req_t{src,vec},
//   sched_state_e {IDLE,REQ,WAIT}.
//  Sub-module iommu_ig_rr_arb: combinational N_SRC round-robin pick (eligible, rr_q -> gnt, valid).
//  Top holds edge regs, pend_q, rr_q, FSM, request latch.
// TESTING
//  1 msi_en=1, iv[CQ]=3 unmasked, ip[CQ] 0->1, ready=1 -> req_valid at t+2, src=0 vec=3; done -> idle, one req.
//  2 iv[FQ]=5, mask[5]=1, ip[FQ] rise -> pend_o=4'b0010, no req; clear mask[5] -> req src=1 vec=5, pend_o=0.
//  3 ip[CQ],ip[FQ] rise same cycle, rr=0 -> CQ then FQ, rr_q=2; retrigger both -> CQ granted first.
//  4 WAIT with done=1,err=1 -> msi_error_o 1 cycle, pend not restored, next eligible proceeds.
//  5 rst_i=1 during WAIT with ip[CQ] held 1 -> outputs 0 next cycle; after release exactly one CQ req.
//  6 msi_en=0, ip[PQ] rises -> no pend; msi_en 0->1 with ip[PQ] still 1 -> no req (edge lost).

Source files
------------

// File: rtl/iommu_ig_pkg.sv
// Shared types and constants for the IOMMU interrupt-generation (MSI) scheduler.
package iommu_ig_pkg;

    typedef enum logic [1:0] {
        SRC_CQ  = 2'd0,
        SRC_FQ  = 2'd1,
        SRC_HPM = 2'd2,
        SRC_PQ  = 2'd3
    } src_e;

    localparam int SRC_W = 2;
    localparam int N_VEC = 16;
    localparam int VEC_W = $clog2(N_VEC);

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [VEC_W-1:0] vec;
    } msi_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/iommu_ig_rr_arb.sv
// Combinational round-robin pick: first eligible source at or above rr_i, wrapping modulo N.
module iommu_ig_rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         eligible_i,
    input  logic [$clog2(N)-1:0] rr_i,
    output logic [$clog2(N)-1:0] gnt_o,
    output logic                 valid_o
);

    always_comb begin
        int                   idx;
        logic [$clog2(N)-1:0] idx_w;
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = 0;
        idx_w   = '0;
        // Walk offsets from farthest to nearest so the nearest eligible source wins.
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(rr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = ($clog2(N))'(idx);
            if (eligible_i[idx_w]) begin
                gnt_o   = idx_w;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iommu_msi_sched.sv
// MSI scheduler: edge-detects pending bits, holds masked messages, and issues one
// round-robin-arbitrated {src,vec} request at a time to the MSI write engine.
module iommu_msi_sched #(
    parameter int  N_SRC = 4,
    parameter int  N_VEC = 16,
    localparam int VEC_W = $clog2(N_VEC)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       msi_en_i,
    input  logic [N_SRC-1:0]           ip_i,
    input  logic [N_SRC*VEC_W-1:0]     iv_i,
    input  logic [N_VEC-1:0]           vec_masked_i,
    output logic                       req_valid_o,
    output logic [$clog2(N_SRC)-1:0]   req_src_o,
    output logic [VEC_W-1:0]           req_vec_o,
    input  logic                       req_ready_i,
    input  logic                       done_i,
    input  logic                       err_i,
    output logic [N_SRC-1:0]           pend_o,
    output logic                       busy_o,
    output logic                       msi_error_o
);

    import iommu_ig_pkg::*;

    localparam int SRC_BITS = $clog2(N_SRC);

    sched_state_e          state_q, state_d;
    logic [N_SRC-1:0]      ip_q;
    logic [N_SRC-1:0]      pend_q, pend_d;
    logic [N_SRC-1:0]      pend_clr;
    logic [N_SRC-1:0]      evt;
    logic [N_SRC-1:0]      elig;
    logic [SRC_BITS-1:0]   rr_q, rr_d;
    logic [SRC_BITS-1:0]   src_q, src_d;
    logic [VEC_W-1:0]      vec_q, vec_d;
    logic [SRC_BITS-1:0]   gnt;
    logic                  gnt_valid;
    logic [VEC_W-1:0]      iv_arr [N_SRC];

    // Edge events are qualified by msi_en_i; an edge while disabled is simply lost.
    assign evt = ip_i & ~ip_q & {N_SRC{msi_en_i}};

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign iv_arr[gi] = iv_i[gi*VEC_W +: VEC_W];
            assign elig[gi]   = pend_q[gi] & ~vec_masked_i[iv_arr[gi]] & msi_en_i;
        end
    endgenerate

    iommu_ig_rr_arb #(
        .N (N_SRC)
    ) u_arb (
        .eligible_i (elig),
        .rr_i       (rr_q),
        .gnt_o      (gnt),
        .valid_o    (gnt_valid)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        src_d       = src_q;
        vec_d       = vec_q;
        pend_clr    = '0;
        msi_error_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    src_d         = gnt;
                    vec_d         = iv_arr[gnt];
                    pend_clr[gnt] = 1'b1;
                    rr_d          = (gnt == SRC_BITS'(N_SRC - 1)) ? '0 : gnt + SRC_BITS'(1);
                    state_d       = REQ;
                end
            end
            REQ: begin
                if (req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (done_i) begin
                    msi_error_o = err_i;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A new event in the grant cycle wins over the clear, so a second MSI follows.
        pend_d = (pend_q & ~pend_clr) | evt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ip_q    <= '0;
            pend_q  <= '0;
            rr_q    <= '0;
            src_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_i;
            pend_q  <= pend_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            vec_q   <= vec_d;
        end
    end

    assign req_valid_o = (state_q == REQ);
    assign req_src_o   = src_q;
    assign req_vec_o   = vec_q;
    assign pend_o      = pend_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_iommu_msi_sched.sv
// Directed bench for iommu_msi_sched: a per-cycle vector table plus hand sequences for
// set-over-clear, reset during WAIT and edges lost while MSI is disabled.
module tb_iommu_msi_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        msi_en;
    logic [3:0]  ip;
    logic [15:0] iv;
    logic [15:0] mask;
    logic        rdy, done, err;
    logic        req_valid;
    logic [1:0]  req_src;
    logic [3:0]  req_vec;
    logic [3:0]  pend;
    logic        busy, merr;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic [3:0]  ip;
        logic [15:0] mask;
        logic        rdy, done, err;
        logic        e_valid;
        logic [1:0]  e_src;
        logic [3:0]  e_vec;
        logic [3:0]  e_pend;
        logic        e_busy, e_merr;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    iommu_msi_sched #(.N_SRC(4), .N_VEC(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .msi_en_i     (msi_en),
        .ip_i         (ip),
        .iv_i         (iv),
        .vec_masked_i (mask),
        .req_valid_o  (req_valid),
        .req_src_o    (req_src),
        .req_vec_o    (req_vec),
        .req_ready_i  (rdy),
        .done_i       (done),
        .err_i        (err),
        .pend_o       (pend),
        .busy_o       (busy),
        .msi_error_o  (merr)
    );

    function automatic vec_t mk(logic en_, logic [3:0] ip_, logic [15:0] mask_,
                                logic rdy_, logic done_, logic err_,
                                logic v_, logic [1:0] s_, logic [3:0] vc_,
                                logic [3:0] p_, logic b_, logic me_);
        vec_t r;
        r.en = en_; r.ip = ip_; r.mask = mask_; r.rdy = rdy_; r.done = done_; r.err = err_;
        r.e_valid = v_; r.e_src = s_; r.e_vec = vc_; r.e_pend = p_; r.e_busy = b_; r.e_merr = me_;
        return r;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic en_, logic [3:0] ip_, logic [15:0] mask_,
                         logic rdy_, logic done_, logic err_);
        msi_en = en_; ip = ip_; mask = mask_; rdy = rdy_; done = done_; err = err_;
    endtask

    initial begin
        int hs;
        // iv: CQ=3, FQ=5, HPM=7, PQ=9
        iv  = 16'h9753;
        rst = 1'b1;
        drive(1'b1, 4'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset.valid", {15'd0, req_valid}, 16'd0);
        chk("reset.src",   {14'd0, req_src},   16'd0);
        chk("reset.vec",   {12'd0, req_vec},   16'd0);
        chk("reset.pend",  {12'd0, pend},      16'd0);
        chk("reset.busy",  {15'd0, busy},      16'd0);
        chk("reset.merr",  {15'd0, merr},      16'd0);
        rst = 1'b0;

        //             en ip  mask     rdy dn er | vld src vec pend busy merr
        tbl.push_back(mk(1, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 3'd0, 4'h0, 0, 0));
        // single CQ edge: pend at t+1, request at t+2
        tbl.push_back(mk(1, 4'h1, 16'h0000, 0, 0, 0, 0, 0, 4'd0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h1, 16'h0000, 0, 0, 0, 0, 0, 4'd0, 4'h1, 0, 0));
        tbl.push_back(mk(1, 4'h1, 16'h0000, 1, 0, 0, 1, 0, 4'd3, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h1, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h1, 16'h0000, 0, 1, 0, 0, 0, 4'd3, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h1, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h0, 0, 0));
        // FQ edge with vector 5 masked: held pending until unmasked
        tbl.push_back(mk(1, 4'h3, 16'h0020, 0, 0, 0, 0, 0, 4'd3, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0020, 0, 0, 0, 0, 0, 4'd3, 4'h2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0020, 0, 0, 0, 0, 0, 4'd3, 4'h2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 1, 1, 4'd5, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0020, 1, 0, 0, 1, 1, 4'd5, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 1, 0, 1, 4'd5, 4'h0, 1, 1));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 1, 0, 1, 4'd5, 4'h0, 0, 0));
        // CQ+FQ together: CQ first, then FQ
        tbl.push_back(mk(1, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h3, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 1, 0, 0, 1, 0, 4'd3, 4'h2, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 0, 0, 0, 4'd3, 4'h2, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 1, 0, 0, 1, 1, 4'd5, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 0, 0, 1, 4'd5, 4'h0, 1, 0));
        // retrigger both: CQ first again; CQ write errors and is not retried
        tbl.push_back(mk(1, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h3, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 1, 0, 0, 1, 0, 4'd3, 4'h2, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 1, 0, 0, 4'd3, 4'h2, 1, 1));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h2, 0, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 1, 0, 0, 1, 1, 4'd5, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h3, 16'h0000, 0, 1, 0, 0, 1, 4'd5, 4'h0, 1, 0));
        // rr pointer now 2: CQ+PQ together -> PQ wins, then CQ
        tbl.push_back(mk(1, 4'h0, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h0, 0, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 0, 0, 0, 0, 1, 4'd5, 4'h9, 0, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 1, 0, 0, 1, 3, 4'd9, 4'h1, 1, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 0, 1, 0, 0, 3, 4'd9, 4'h1, 1, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 0, 0, 0, 0, 3, 4'd9, 4'h1, 0, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 1, 0, 0, 1, 0, 4'd3, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h9, 16'h0000, 0, 1, 0, 0, 0, 4'd3, 4'h0, 1, 0));
        tbl.push_back(mk(1, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 4'd3, 4'h0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].ip, tbl[i].mask, tbl[i].rdy, tbl[i].done, tbl[i].err);
            #1;
            $display("vec %0d ip=%h mask=%h rdy=%b done=%b err=%b -> valid=%b src=%0d vec=%0d pend=%h busy=%b merr=%b",
                     i, ip, mask, rdy, done, err, req_valid, req_src, req_vec, pend, busy, merr);
            chk($sformatf("v%0d.valid", i), {15'd0, req_valid}, {15'd0, tbl[i].e_valid});
            chk($sformatf("v%0d.src", i),   {14'd0, req_src},   {14'd0, tbl[i].e_src});
            chk($sformatf("v%0d.vec", i),   {12'd0, req_vec},   {12'd0, tbl[i].e_vec});
            chk($sformatf("v%0d.pend", i),  {12'd0, pend},      {12'd0, tbl[i].e_pend});
            chk($sformatf("v%0d.busy", i),  {15'd0, busy},      {15'd0, tbl[i].e_busy});
            chk($sformatf("v%0d.merr", i),  {15'd0, merr},      {15'd0, tbl[i].e_merr});
            step();
        end

        // Set-over-clear: CQ pending while masked, then unmask in the same cycle as a new edge.
        drive(1, 4'h1, 16'h0008, 0, 0, 0); step();
        drive(1, 4'h0, 16'h0008, 0, 0, 0);
        chk("soc.pend_masked", {12'd0, pend}, 16'h1);
        chk("soc.busy_masked", {15'd0, busy}, 16'd0);
        step();
        drive(1, 4'h1, 16'h0000, 0, 0, 0);
        chk("soc.grant_cycle_valid", {15'd0, req_valid}, 16'd0);
        step();
        $display("soc first req valid=%b src=%0d pend=%h", req_valid, req_src, pend);
        chk("soc.req1_valid", {15'd0, req_valid}, 16'd1);
        chk("soc.req1_src",   {14'd0, req_src},   16'd0);
        chk("soc.pend_kept",  {12'd0, pend},      16'h1);
        drive(1, 4'h1, 16'h0000, 1, 0, 0); step();
        drive(1, 4'h1, 16'h0000, 0, 1, 0); step();
        drive(1, 4'h1, 16'h0000, 0, 0, 0);
        chk("soc.idle_busy", {15'd0, busy}, 16'd0);
        step();
        $display("soc second req valid=%b src=%0d pend=%h", req_valid, req_src, pend);
        chk("soc.req2_valid", {15'd0, req_valid}, 16'd1);
        chk("soc.req2_pend",  {12'd0, pend},      16'h0);
        drive(1, 4'h1, 16'h0000, 1, 0, 0); step();
        drive(1, 4'h0, 16'h0000, 0, 1, 0); step();
        drive(1, 4'h0, 16'h0000, 0, 0, 0); step();
        chk("soc.end_busy", {15'd0, busy}, 16'd0);

        // Reset while WAIT with ip[CQ] held high: one CQ request afterwards.
        drive(1, 4'h1, 16'h0000, 1, 0, 0);
        step(); step(); step();
        chk("rst.pre_busy",  {15'd0, busy},      16'd1);
        chk("rst.pre_valid", {15'd0, req_valid}, 16'd0);
        rst = 1'b1;
        step();
        chk("rst.valid", {15'd0, req_valid}, 16'd0);
        chk("rst.busy",  {15'd0, busy},      16'd0);
        chk("rst.pend",  {12'd0, pend},      16'd0);
        chk("rst.src",   {14'd0, req_src},   16'd0);
        chk("rst.vec",   {12'd0, req_vec},   16'd0);
        rst = 1'b0;
        drive(1, 4'h1, 16'h0000, 1, 1, 0);
        hs = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_valid && rdy) begin
                hs++;
                chk("rst.req_src", {14'd0, req_src}, 16'd0);
                chk("rst.req_vec", {12'd0, req_vec}, 16'd3);
            end
            step();
        end
        $display("after reset release: %0d request(s) accepted", hs);
        chk("rst.req_count", 16'(hs), 16'd1);

        // Edge while disabled is lost; enabling with the level still high issues nothing.
        drive(0, 4'h0, 16'h0000, 0, 0, 0); step(); step();
        drive(0, 4'h8, 16'h0000, 0, 0, 0); step(); step(); step();
        chk("dis.pend",  {12'd0, pend},      16'd0);
        chk("dis.valid", {15'd0, req_valid}, 16'd0);
        drive(1, 4'h8, 16'h0000, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("dis.en_valid%0d", c), {15'd0, req_valid}, 16'd0);
            step();
        end
        chk("dis.en_pend", {12'd0, pend}, 16'd0);
        drive(1, 4'h0, 16'h0000, 1, 0, 0); step();
        drive(1, 4'h8, 16'h0000, 1, 0, 0); step();
        $display("pq re-edge pend=%h", pend);
        chk("dis.new_edge_pend", {12'd0, pend}, 16'h8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
